// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp patterns and lamp decode for the
// two-road traffic controller.
`default_nettype none

package traffic_pkg;

  typedef enum logic [2:0] {
    G1    = 3'd0,
    Y1    = 3'd1,
    AR1   = 3'd2,
    G2    = 3'd3,
    Y2    = 3'd4,
    AR2   = 3'd5,
    NIGHT = 3'd6
  } state_t;

  // Lamp bit order is [green, red, yellow].
  localparam logic [2:0] L_GREEN  = 3'b100;
  localparam logic [2:0] L_RED    = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;
  localparam logic [2:0] L_OFF    = 3'b000;

  // Returns {light1, light2} for a given state and flash phase.
  function automatic logic [5:0] lamp_decode(input state_t s, input logic flash);
    logic [5:0] l;
    l = {L_RED, L_RED};
    case (s)
      G1:      l = {L_GREEN,  L_RED};
      Y1:      l = {L_YELLOW, L_RED};
      AR1:     l = {L_RED,    L_RED};
      G2:      l = {L_RED,    L_GREEN};
      Y2:      l = {L_RED,    L_YELLOW};
      AR2:     l = {L_RED,    L_RED};
      NIGHT:   l = {2'b00, flash, 2'b00, flash};
      default: l = {L_RED,    L_RED};
    endcase
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// phase_timer: loadable tick-enabled down-counter with a zero flag; it
// saturates at zero rather than wrapping.
`default_nettype none

module phase_timer #(
  parameter int                CNT_W   = 6,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (tick) begin
      if (load) begin
        count <= load_val;
      end else if (!zero) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-road light controller with all-red clearance,
// road-1 green extension on an idle road 2, and flashing-yellow night mode.
`default_nettype none

module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             sensor2,
  input  logic             night_mode,
  output logic [2:0]       light1,
  output logic [2:0]       light2,
  output logic [CNT_W-1:0] count
);

  localparam int T_MAX = (2 ** CNT_W) - 1;

  if (T_GREEN < 1 || T_GREEN > T_MAX) begin : g_bad_green
    $error("T_GREEN must lie in 1..2^CNT_W-1");
  end
  if (T_YELLOW < 1 || T_YELLOW > T_MAX) begin : g_bad_yellow
    $error("T_YELLOW must lie in 1..2^CNT_W-1");
  end
  if (T_ALLRED < 1 || T_ALLRED > T_MAX) begin : g_bad_allred
    $error("T_ALLRED must lie in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);

  state_t           state;
  state_t           next_state;
  logic             flash;
  logic             next_flash;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_GREEN)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero)
  );

  // Expiry gates every transition except leaving NIGHT, which only needs a tick.
  always_comb begin
    next_state = state;
    next_flash = flash;
    load       = 1'b0;
    load_val   = '0;
    if (tick) begin
      if (state == NIGHT) begin
        if (!night_mode) begin
          next_state = AR2;
          next_flash = 1'b0;
          load       = 1'b1;
          load_val   = LD_ALLRED;
        end else begin
          next_flash = ~flash;
        end
      end else if (zero) begin
        load = 1'b1;
        case (state)
          G1: begin
            if (sensor2) begin
              next_state = Y1;
              load_val   = LD_YELLOW;
            end else begin
              load = 1'b0;
            end
          end
          Y1: begin
            next_state = AR1;
            load_val   = LD_ALLRED;
          end
          AR1: begin
            if (night_mode) begin
              next_state = NIGHT;
              next_flash = 1'b1;
            end else begin
              next_state = G2;
              load_val   = LD_GREEN;
            end
          end
          G2: begin
            next_state = Y2;
            load_val   = LD_YELLOW;
          end
          Y2: begin
            next_state = AR2;
            load_val   = LD_ALLRED;
          end
          AR2: begin
            if (night_mode) begin
              next_state = NIGHT;
              next_flash = 1'b1;
            end else begin
              next_state = G1;
              load_val   = LD_GREEN;
            end
          end
          default: begin
            next_state = G1;
            next_flash = 1'b0;
            load_val   = LD_GREEN;
          end
        endcase
      end
    end
  end

  // Lamps are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= G1;
      flash  <= 1'b0;
      light1 <= L_GREEN;
      light2 <= L_RED;
    end else begin
      state            <= next_state;
      flash            <= next_flash;
      {light1, light2} <= lamp_decode(next_state, next_flash);
    end
  end

  a_green_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(light1[2] && light2[2])
  );

endmodule

`default_nettype wire

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: vector table, hand sequences for gating,
// async reset and night mode, then a randomised run against a reference model.
`default_nettype none

module tb_traffic_ctrl_param;

  localparam int CNT_W = 6;
  localparam int TG = 4;
  localparam int TY = 2;
  localparam int TA = 1;

  localparam logic [2:0] GRN = 3'b100;
  localparam logic [2:0] RED = 3'b010;
  localparam logic [2:0] YEL = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam int S_G1 = 0, S_Y1 = 1, S_AR1 = 2, S_G2 = 3, S_Y2 = 4, S_AR2 = 5, S_N = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             sensor2 = 1'b0;
  logic             night_mode = 1'b0;
  logic [2:0]       light1;
  logic [2:0]       light2;
  logic [CNT_W-1:0] count;

  traffic_ctrl_param #(
    .CNT_W    (CNT_W),
    .T_GREEN  (TG),
    .T_YELLOW (TY),
    .T_ALLRED (TA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .sensor2    (sensor2),
    .night_mode (night_mode),
    .light1     (light1),
    .light2     (light2),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       l1;
    logic [2:0]       l2;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    logic             tk;
    logic             s2;
    logic             nm;
    logic [2:0]       l1;
    logic [2:0]       l2;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[21];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic tk, input logic s2, input logic nm,
                              input logic [2:0] l1, input logic [2:0] l2, input int c);
    vec_t v;
    v.tk = tk; v.s2 = s2; v.nm = nm; v.l1 = l1; v.l2 = l2; v.cnt = CNT_W'(c);
    return v;
  endfunction

  task automatic check(input string name);
    exp_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got light1=%b light2=%b count=%0d", name, light1, light2, count);
    end else begin
      e = expq.pop_front();
      if (light1 !== e.l1 || light2 !== e.l2 || count !== e.cnt) begin
        fails++;
        $display("FAIL %s: got light1=%b light2=%b count=%0d, expected light1=%b light2=%b count=%0d",
                 name, light1, light2, count, e.l1, e.l2, e.cnt);
      end
    end
  endtask

  task automatic push(input logic [2:0] l1, input logic [2:0] l2, input int c);
    exp_t e;
    e.l1 = l1; e.l2 = l2; e.cnt = CNT_W'(c);
    expq.push_back(e);
  endtask

  task automatic step(input logic tk, input logic s2, input logic nm,
                      input logic [2:0] l1, input logic [2:0] l2, input int c, input string name);
    tick = tk; sensor2 = s2; night_mode = nm;
    push(l1, l2, c);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 1'b1; sensor2 = 1'b1; night_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(GRN, RED, TG - 1);
    check("reset_state");
    rst_n = 1'b1;
  endtask

  // Reference model state.
  int   ms;
  int   mc;
  logic mf;

  function automatic int phase_len(input int s);
    case (s)
      S_G1, S_G2:   return TG;
      S_Y1, S_Y2:   return TY;
      S_AR1, S_AR2: return TA;
      default:      return 1;
    endcase
  endfunction

  task automatic model_tick(input logic s2, input logic nm);
    if (ms == S_N) begin
      if (!nm) begin ms = S_AR2; mc = phase_len(S_AR2) - 1; mf = 1'b0; end
      else mf = ~mf;
    end else if (mc > 0) begin
      mc = mc - 1;
    end else begin
      int nxt;
      nxt = ms;
      case (ms)
        S_G1:  nxt = s2 ? S_Y1 : S_G1;
        S_Y1:  nxt = S_AR1;
        S_AR1: nxt = nm ? S_N : S_G2;
        S_G2:  nxt = S_Y2;
        S_Y2:  nxt = S_AR2;
        S_AR2: nxt = nm ? S_N : S_G1;
        default: nxt = S_G1;
      endcase
      if (nxt == S_N) begin ms = S_N; mc = 0; mf = 1'b1; end
      else if (nxt != ms) begin ms = nxt; mc = phase_len(nxt) - 1; end
    end
  endtask

  function automatic logic [5:0] model_lamps(input int s, input logic f);
    case (s)
      S_G1:    return {GRN, RED};
      S_Y1:    return {YEL, RED};
      S_G2:    return {RED, GRN};
      S_Y2:    return {RED, YEL};
      S_N:     return {2'b00, f, 2'b00, f};
      default: return {RED, RED};
    endcase
  endfunction

  initial begin
    logic [5:0] lp;
    logic [2:0] p1, p2;
    logic       tk, s2, nm;

    // Reset release and full cycle with sensor2=1, then green extension.
    tbl[0]  = mk(1, 1, 0, GRN, RED, 2);
    tbl[1]  = mk(1, 1, 0, GRN, RED, 1);
    tbl[2]  = mk(1, 1, 0, GRN, RED, 0);
    tbl[3]  = mk(1, 1, 0, YEL, RED, 1);
    tbl[4]  = mk(1, 1, 0, YEL, RED, 0);
    tbl[5]  = mk(1, 1, 0, RED, RED, 0);
    tbl[6]  = mk(1, 1, 0, RED, GRN, 3);
    tbl[7]  = mk(1, 1, 0, RED, GRN, 2);
    tbl[8]  = mk(1, 1, 0, RED, GRN, 1);
    tbl[9]  = mk(1, 1, 0, RED, GRN, 0);
    tbl[10] = mk(1, 1, 0, RED, YEL, 1);
    tbl[11] = mk(1, 1, 0, RED, YEL, 0);
    tbl[12] = mk(1, 1, 0, RED, RED, 0);
    tbl[13] = mk(1, 1, 0, GRN, RED, 3);
    tbl[14] = mk(1, 0, 0, GRN, RED, 2);
    tbl[15] = mk(1, 0, 0, GRN, RED, 1);
    tbl[16] = mk(1, 0, 0, GRN, RED, 0);
    tbl[17] = mk(1, 0, 0, GRN, RED, 0);
    tbl[18] = mk(1, 0, 0, GRN, RED, 0);
    tbl[19] = mk(1, 0, 0, GRN, RED, 0);
    tbl[20] = mk(1, 1, 0, YEL, RED, 1);

    do_reset();
    for (int i = 0; i < 21; i++)
      step(tbl[i].tk, tbl[i].s2, tbl[i].nm, tbl[i].l1, tbl[i].l2, tbl[i].cnt, $sformatf("vec%0d", i));

    // Tick gated low mid-Y1: everything freezes, then resumes.
    for (int i = 0; i < 10; i++) step(0, 1, 0, YEL, RED, 1, "tick_gated_hold");
    step(1, 1, 0, YEL, RED, 0, "resume_y1");
    step(1, 1, 0, RED, RED, 0, "resume_ar1");

    // Asynchronous reset asserted between clock edges while in AR1.
    #2;
    rst_n = 1'b0;
    #1;
    push(GRN, RED, TG - 1);
    check("async_reset_midcycle");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Night mode requested during G2.
    for (int i = 0; i < 7; i++)
      step(1, 1, 0, tbl[i].l1, tbl[i].l2, tbl[i].cnt, "pre_night");
    step(1, 1, 1, RED, GRN, 2, "night_g2_runs");
    step(1, 1, 1, RED, GRN, 1, "night_g2_runs");
    step(1, 1, 1, RED, GRN, 0, "night_g2_runs");
    step(1, 1, 1, RED, YEL, 1, "night_y2_runs");
    step(1, 1, 1, RED, YEL, 0, "night_y2_runs");
    step(1, 1, 1, RED, RED, 0, "night_ar2_runs");
    step(1, 1, 1, YEL, YEL, 0, "night_flash_on");
    step(1, 1, 1, OFF, OFF, 0, "night_flash_off");
    step(1, 1, 1, YEL, YEL, 0, "night_flash_on");
    step(0, 1, 1, YEL, YEL, 0, "night_no_tick_hold");
    step(1, 1, 1, OFF, OFF, 0, "night_flash_off");
    step(1, 1, 0, RED, RED, 0, "night_exit_ar2");
    step(1, 1, 0, GRN, RED, 3, "night_exit_g1");

    // Random run against the reference model.
    do_reset();
    ms = S_G1; mc = TG - 1; mf = 1'b0;
    p1 = GRN; p2 = RED;
    nm = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      tk = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) nm = ~nm;
      tick = tk; sensor2 = s2; night_mode = nm;
      if (tk) model_tick(s2, nm);
      lp = model_lamps(ms, mf);
      push(lp[5:3], lp[2:0], mc);
      @(posedge clk);
      #1;
      check("random_model");
      tests++;
      if (light1[2] && light2[2]) begin
        fails++;
        $display("FAIL both_green: light1=%b light2=%b, required green bits not both set", light1, light2);
      end
      if ((light1 == GRN && p1 != GRN) || (light2 == GRN && p2 != GRN)) begin
        tests++;
        if (!(p1 == RED && p2 == RED)) begin
          fails++;
          $display("FAIL green_after_allred: previous light1=%b light2=%b, required 010/010", p1, p2);
        end
      end
      p1 = light1; p2 = light2;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
